// File: rtl/seg7_pkg.sv
// Shared constants for the seg7 scan display: digit count, blank pattern and
// the active-low hex glyph table (bit 0 = CA ... bit 6 = CG).
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned IDX_W      = 3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry n is the glyph for hex digit n; index 0 is the rightmost element.
    localparam logic [15:0][6:0] HEX_GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-digit to active-low seven-segment glyph lookup.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_GLYPHS[digit_i];

endmodule

// File: rtl/seg7_scan_display.sv
// Eight-digit multiplexed seven-segment scanner with per-slot anti-ghost blanking.
// Optional leading-zero blanking is compiled in with macro SEG7_LZB_EN.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp_in,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PRESC_BLANK = PW'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      value_sh_q;
    logic [7:0]       en_sh_q;
    logic [7:0]       dp_sh_q;
    logic             frame_tick_q;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             slot_end;
    logic             wrap;
    logic [3:0]       cur_digit;
    logic [6:0]       glyph;
    logic             lzb_ok;
    logic             lit;

    assign slot_end = (presc_q == PRESC_LAST);
    assign wrap     = slot_end && (idx_q == IDX_LAST);

    always_comb begin
        presc_d = slot_end ? '0 : presc_q + PW'(1);
        idx_d   = slot_end ? idx_q + IDX_W'(1) : idx_q;
    end

    assign cur_digit = value_sh_q[{idx_q, 2'b00} +: 4];

    seg7_hex_decode u_hex_decode (
        .digit_i (cur_digit),
        .seg_o   (glyph)
    );

`ifdef SEG7_LZB_EN
    // Highest nonzero shadow digit; stays 0 for an all-zero word so "0" still shows.
    logic [IDX_W-1:0] top_digit;

    always_comb begin
        top_digit = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (value_sh_q[4*i +: 4] != 4'h0) begin
                top_digit = IDX_W'(i);
            end
        end
    end

    assign lzb_ok = (idx_q <= top_digit);
`else
    assign lzb_ok = 1'b1;
`endif

    assign lit = (presc_q >= PRESC_BLANK) && en_sh_q[idx_q] && lzb_ok;

    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (lit) begin
            an_d[idx_q] = 1'b0;
            seg_d       = glyph;
            dp_d        = ~dp_sh_q[idx_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    // Inputs are only sampled on the 7->0 wrap edge so a frame is never torn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_sh_q <= '0;
            en_sh_q    <= '0;
            dp_sh_q    <= '0;
        end else if (wrap) begin
            value_sh_q <= value;
            en_sh_q    <= digit_en;
            dp_sh_q    <= dp_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_tick_q <= 1'b0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
        end else begin
            frame_tick_q <= wrap;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: per-slot expectations are queued per frame
// and a monitor compares each observed output slot. Honours SEG7_LZB_EN.
`timescale 1ns/1ps
module tb_seg7_scan_display;

    localparam int unsigned DIV   = 8;
    localparam int unsigned BLANK = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] value = '0;
    logic [7:0]  digit_en = '0;
    logic [7:0]  dp_in = '0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg7_scan_display #(
        .REFRESH_DIV (DIV),
        .BLANK_CYC   (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .digit_en   (digit_en),
        .dp_in      (dp_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] lit_cnt;
        logic [3:0] first_lit;
    } slot_t;

    localparam slot_t DARK = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, lit_cnt: 4'd0, first_lit: 4'd0};

    // Hand-written active-low glyphs, 0..F.
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    slot_t sb[$];
    int    n_vec  = 0;
    int    n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic slot_t exp_slot(input logic [31:0] v, input logic [7:0] en,
                                       input logic [7:0] dpi, input int s);
        slot_t e;
        bit    lit;
        lit = en[s];
`ifdef SEG7_LZB_EN
        begin
            int hi;
            hi = 0;
            for (int i = 1; i < 8; i++) if (v[4*i +: 4] != 4'h0) hi = i;
            if (s > hi) lit = 1'b0;
        end
`endif
        e = DARK;
        if (lit) begin
            e.an        = 8'hFF;
            e.an[s]     = 1'b0;
            e.seg       = GLYPH[v[4*s +: 4]];
            e.dp        = ~dpi[s];
            e.lit_cnt   = 4'd6;
            e.first_lit = 4'd3;
        end
        return e;
    endfunction

    task automatic push_frame(input logic [31:0] v, input logic [7:0] en, input logic [7:0] dpi);
        for (int s = 0; s < 8; s++) sb.push_back(exp_slot(v, en, dpi, s));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns 1 time unit after the negedge on which frame_tick is seen.
    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 200);
        check("frame_tick_seen", {31'd0, frame_tick}, 32'd1);
        #1;
    endtask

    // Release reset, require 64 dark cycles up to the first frame_tick.
    task automatic release_and_sync();
        int n;
        bit lit_seen;
        rst = 1'b0;
        n = 0;
        lit_seen = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (an !== 8'hFF) lit_seen = 1'b1;
        end while (!frame_tick && n < 200);
        check("first_tick_delay", n, 64);
        check("dark_before_first_wrap", {31'd0, lit_seen}, 32'd0);
        #1;
    endtask

    initial begin : monitor
        int    phase;
        int    slot;
        int    since;
        bit    synced;
        bit    ticked;
        bit    steady;
        slot_t obs;
        slot_t exp_s;
        phase  = 0;
        slot   = 0;
        since  = 0;
        synced = 1'b0;
        ticked = 1'b0;
        steady = 1'b1;
        obs    = DARK;
        forever begin
            @(negedge clk);
            if (rst) begin
                synced = 1'b0;
                ticked = 1'b0;
                continue;
            end
            since++;
            if (synced) begin
                phase++;
                if (an !== 8'hFF) begin
                    if (obs.lit_cnt == 4'd0) begin
                        obs.an        = an;
                        obs.seg       = seg;
                        obs.dp        = dp;
                        obs.first_lit = 4'(phase);
                    end else if (an !== obs.an || seg !== obs.seg || dp !== obs.dp) begin
                        steady = 1'b0;
                    end
                    obs.lit_cnt = obs.lit_cnt + 4'd1;
                end else if (seg !== 7'h7F || dp !== 1'b1) begin
                    steady = 1'b0;
                end
                if (phase == 8) begin
                    if (sb.size() > 0) begin
                        exp_s = sb.pop_front();
                        n_vec++;
                        if (obs !== exp_s || !steady) begin
                            n_fail++;
                            $display("FAIL slot%0d: got an=%h seg=%h dp=%b lit=%0d first=%0d steady=%0b, expected an=%h seg=%h dp=%b lit=%0d first=%0d steady=1",
                                     slot, obs.an, obs.seg, obs.dp, obs.lit_cnt, obs.first_lit,
                                     steady, exp_s.an, exp_s.seg, exp_s.dp, exp_s.lit_cnt,
                                     exp_s.first_lit);
                        end
                    end
                    slot++;
                    phase  = 0;
                    obs    = DARK;
                    steady = 1'b1;
                end
            end
            if (frame_tick) begin
                if (ticked) check("frame_tick_period", since, 64);
                ticked = 1'b1;
                since  = 0;
                synced = 1'b1;
                phase  = 0;
                slot   = 0;
                obs    = DARK;
                steady = 1'b1;
            end
        end
    end

    initial begin : stimulus
        value    = 32'h0000_1234;
        digit_en = 8'hFF;
        dp_in    = 8'h00;
        rst      = 1'b1;
        wait_cycles(3);
        check("reset_an", {24'd0, an}, 32'hFF);
        check("reset_seg", {25'd0, seg}, 32'h7F);
        check("reset_dp", {31'd0, dp}, 32'd1);
        check("reset_frame_tick", {31'd0, frame_tick}, 32'd0);

        release_and_sync();
        push_frame(32'h0000_1234, 8'hFF, 8'h00);
        // Change during slot 3: this frame must still show the old word.
        wait_cycles(28);
        value = 32'h0000_0000;

        wait_tick();
        push_frame(32'h0000_0000, 8'hFF, 8'h00);
        // Change on the cycle whose closing edge is the wrap edge.
        wait_cycles(63);
        value    = 32'h89AB_CDEF;
        digit_en = 8'hFF;
        dp_in    = 8'hA5;

        wait_tick();
        push_frame(32'h89AB_CDEF, 8'hFF, 8'hA5);
        wait_cycles(20);
        value    = 32'h0000_1234;
        digit_en = 8'h0F;
        dp_in    = 8'h01;

        wait_tick();
        push_frame(32'h0000_1234, 8'h0F, 8'h01);
        wait_cycles(10);
        value    = 32'h0056_7000;
        digit_en = 8'hFF;
        dp_in    = 8'h00;

        wait_tick();
        push_frame(32'h0056_7000, 8'hFF, 8'h00);

        // Asynchronous reset in the middle of digit 5's lit window.
        wait_tick();
        wait_cycles(44);
        check("pre_reset_an", {24'd0, an}, 32'hDF);
        value    = 32'h0000_1234;
        digit_en = 8'hFF;
        dp_in    = 8'h00;
        sb.delete();
        rst = 1'b1;
        #1;
        check("async_reset_an", {24'd0, an}, 32'hFF);
        check("async_reset_seg", {25'd0, seg}, 32'h7F);
        check("async_reset_dp", {31'd0, dp}, 32'd1);
        wait_cycles(3);
        check("held_reset_frame_tick", {31'd0, frame_tick}, 32'd0);
        check("held_reset_an", {24'd0, an}, 32'hFF);

        release_and_sync();
        push_frame(32'h0000_1234, 8'hFF, 8'h00);
        wait_tick();
        wait_cycles(2);
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
SEG7_SCAN_DISPLAY -- requirements
Module: seg7_scan_display

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000: clock cycles per digit slot (1 ms at 100 MHz); legal range is BLANK_CYC+2 or greater.
REQ-002 The block SHALL have parameter BLANK_CYC, default 64: cycles at the start of each slot during which all anodes are off (anti-ghosting).
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, 100 MHz.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port value, input, 32 bits: eight hex digits, digit i = value[4i+3:4i], digit 0 rightmost; driven directly by the keypad receiver's 32-bit digit word.
REQ-006 The block SHALL have port digit_en, input, 8 bits: per-digit enable, 1 = digit may light.
REQ-007 The block SHALL have port dp_in, input, 8 bits: per-digit decimal point request, 1 = lit.
REQ-008 The block SHALL have port an, output, 8 bits: anodes, active-low, an[i] selects digit i.
REQ-009 The block SHALL have port seg, output, 7 bits: cathodes, active-low, seg[0]=CA through seg[6]=CG.
REQ-010 The block SHALL have port dp, output, 1 bit: decimal point cathode, active-low.
REQ-011 The block SHALL have port frame_tick, output, 1 bit: one-cycle pulse marking the start of each scan frame.

Function
REQ-012 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap; at terminal count a 3-bit digit index SHALL increment, with 7 wrapping to 0.
REQ-013 One frame SHALL be 8*REFRESH_DIV cycles; digits SHALL be scanned in order 0..7.
REQ-014 value, digit_en and dp_in SHALL be captured into shadow registers only on the clock edge where the index wraps 7->0; changes mid-frame SHALL NOT appear until the next frame.
REQ-015 frame_tick SHALL be high for exactly the one cycle following the 7->0 wrap edge.
REQ-016 an, seg and dp SHALL be registered, with one cycle latency from the prescaler/index state.
REQ-017 an[idx] SHALL be low only when the prescaler is at or above BLANK_CYC and the shadow digit_en[idx] is 1; all other anode bits SHALL be 1.
REQ-018 seg SHALL be the fixed hex decode of the shadow digit (0-F, including A b C d E F glyphs); dp SHALL be ~shadow dp_in[idx].
REQ-019 When the current digit is dark (blanked or disabled), seg SHALL be 7'h7F and dp SHALL be 1.
REQ-020 Simultaneous wrap and input change: the value sampled on the wrap edge SHALL be the value captured.

Reset
REQ-021 While rst is high: an=8'hFF, seg=7'h7F, dp=1, frame_tick=0, prescaler=0, index=0, and shadow registers=0.
REQ-022 Reset asserted mid-slot SHALL force outputs immediately, without waiting for a clock edge.
REQ-023 After reset release, scanning SHALL resume at digit 0, prescaler 0, showing shadow zeros until the first wrap.

Configuration
REQ-024 With macro SEG7_LZB_EN defined, leading-zero blanking SHALL apply: digits above the highest nonzero shadow digit are dark, digit 0 is always eligible, and value 0 displays a single "0".
REQ-025 Without SEG7_LZB_EN, every enabled digit SHALL be displayed, including leading zeros.

Structure
REQ-026 Package seg7_pkg SHALL hold NUM_DIGITS=8, SEG_BLANK=7'h7F, and the 16-entry active-low hex glyph table.
REQ-027 A combinational sub-module seg7_hex_decode (4-bit in, 7-bit out) SHALL implement the glyph lookup.
REQ-028 Counters, shadow registers and blanking logic SHALL reside in seg7_scan_display.

Verification (REFRESH_DIV=8, BLANK_CYC=2)
REQ-029 Reset test: assert rst mid-slot of digit 5 -> an=FF, seg=7F, dp=1 in the same cycle; after release, first lit anode is an=FE, 3 cycles into the slot.
REQ-030 Display test: value=32'h00001234, digit_en=FF, LZB off -> slots 0..3 give seg 19,30,24,79; slots 4..7 give seg 40; each slot has an low for 6 of 8 cycles.
REQ-031 Leading-zero test: same stimulus with SEG7_LZB_EN -> an stays FF for slots 4..7; value=0 -> only digit 0 lit, seg=40.
REQ-032 Mid-frame change: value changes during slot 3 -> slots 3..7 show the old digits; new digits appear from the slot after the next frame_tick.
REQ-033 Frame timing: frame_tick pulses every 64 cycles, each pulse 1 cycle wide, aligned with the start of slot 0.
REQ-034 Enable and decimal point: digit_en=8'h0F with dp_in=8'h01 -> slots 4..7 dark; dp=0 only during slot 0's lit cycles.
